// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcode map, FSM states
// and default bus widths.
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    // Opcode lives in the top two bits of the instruction word
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_JZ   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_HALT   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// Memory wait counter: counts FETCH cycles without MEM_READY and flags the
// cycle on which the count would reach TIMEOUT.
module seq_wait_timer
    import fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear has priority so a ready on the last allowed cycle is never a fault
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = inc_i && !clear_i && (count_d == 8'(TIMEOUT));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: fetches an instruction word, latches it in the IR
// and issues one PC step per instruction (increment or jump-target load).
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              cond_flag_i,
    output logic              mem_req_o,
    output logic              pc_step_o,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic [DATA_W-1:0] ir_out_o,
    output logic              ir_valid_o,
    output logic              halted_o,
    output logic              fault_o
);

    state_t            state_q;
    logic [DATA_W-1:0] ir_q;
    logic [1:0]        opcode;
    logic              in_fetch;
    logic              in_decode;
    logic              timer_clr;
    logic              timer_inc;
    logic              timer_expire;

    assign opcode    = ir_q[DATA_W-1 -: 2];
    assign in_fetch  = (state_q == ST_FETCH);
    assign in_decode = (state_q == ST_DECODE);
    assign timer_clr = !in_fetch || mem_ready_i;
    assign timer_inc = in_fetch && !mem_ready_i;

    seq_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .clear_i (timer_clr),
        .inc_i   (timer_inc),
        .expire_o(timer_expire)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_i) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ready_i) begin
                        ir_q    <= mem_rdata_i;
                        state_q <= ST_DECODE;
                    end else if (timer_expire) begin
                        state_q <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_HALT) state_q <= ST_HALT;
                    else if (run_i)        state_q <= ST_FETCH;
                    else                   state_q <= ST_IDLE;
                end
                ST_HALT, ST_FAULT: state_q <= state_q;
                default:           state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes are only live in DECODE; JZ needs the flag of that same cycle
    assign mem_req_o   = in_fetch;
    assign pc_step_o   = in_decode && (opcode != OP_HALT);
    assign pc_load_o   = in_decode && ((opcode == OP_JMP) ||
                                       ((opcode == OP_JZ) && cond_flag_i));
    assign ir_valid_o  = in_decode && (opcode == OP_NOP);
    assign halted_o    = (state_q == ST_HALT);
    assign fault_o     = (state_q == ST_FAULT);
    assign pc_target_o = ir_q[ADDR_W-1:0];
    assign ir_out_o    = ir_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// instruction stream checked against a per-instruction behavioural model.
module tb_fetch_sequencer;

    localparam int TO = 15;

    // Status vector order: {mem_req, pc_step, pc_load, ir_valid, halted, fault}
    localparam logic [5:0] S_NONE   = 6'b000000;
    localparam logic [5:0] S_REQ    = 6'b100000;
    localparam logic [5:0] S_OP     = 6'b010100;
    localparam logic [5:0] S_INC    = 6'b010000;
    localparam logic [5:0] S_LD     = 6'b011000;
    localparam logic [5:0] S_HALTED = 6'b000010;
    localparam logic [5:0] S_FAULT  = 6'b000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       cond = 1'b0;
    logic       mem_req, pc_step, pc_load, ir_valid, halted, fault;
    logic [5:0] pc_target;
    logic [7:0] ir_out;
    logic [5:0] st;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign st = {mem_req, pc_step, pc_load, ir_valid, halted, fault};

    fetch_sequencer #(
        .ADDR_W(6),
        .DATA_W(8),
        .TIMEOUT(TO)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .run_i      (run),
        .mem_ready_i(mem_ready),
        .mem_rdata_i(rdata),
        .cond_flag_i(cond),
        .mem_req_o  (mem_req),
        .pc_step_o  (pc_step),
        .pc_load_o  (pc_load),
        .pc_target_o(pc_target),
        .ir_out_o   (ir_out),
        .ir_valid_o (ir_valid),
        .halted_o   (halted),
        .fault_o    (fault)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; cond = 1'b0; rdata = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1; rdata = 8'hFF;
        tick();
        tick();
        #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL reset_status got=%b exp=%b", st, S_NONE); end
        n_tests++; if (ir_out !== 8'h00) begin n_fail++; $display("FAIL reset_ir got=%h exp=00", ir_out); end
        n_tests++; if (pc_target !== 6'h00) begin n_fail++; $display("FAIL reset_target got=%h exp=00", pc_target); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; rdata = 8'h05;
        #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL basic_c0 got=%b exp=%b", st, S_NONE); end
        tick(); #1;
        n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL basic_c1 got=%b exp=%b", st, S_REQ); end
        tick();
        rdata = 8'h41; #1;
        n_tests++; if (st !== S_OP) begin n_fail++; $display("FAIL basic_c2 got=%b exp=%b", st, S_OP); end
        n_tests++; if (ir_out !== 8'h05) begin n_fail++; $display("FAIL basic_c2_ir got=%h exp=05", ir_out); end
        tick(); #1;
        n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL basic_c3 got=%b exp=%b", st, S_REQ); end
        tick();
        run = 1'b0; #1;
        n_tests++; if (st !== S_LD) begin n_fail++; $display("FAIL basic_c4 got=%b exp=%b", st, S_LD); end
        n_tests++; if (pc_target !== 6'h01) begin n_fail++; $display("FAIL basic_c4_target got=%h exp=01", pc_target); end
        tick(); #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL basic_c5_idle got=%b exp=%b", st, S_NONE); end
    endtask

    task automatic test_jz();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; rdata = 8'h8A;
        tick(); tick();
        cond = 1'b0; #1;
        n_tests++; if (st !== S_INC) begin n_fail++; $display("FAIL jz_not_taken got=%b exp=%b", st, S_INC); end
        tick(); tick();
        cond = 1'b1; #1;
        n_tests++; if (st !== S_LD) begin n_fail++; $display("FAIL jz_taken got=%b exp=%b", st, S_LD); end
        n_tests++; if (pc_target !== 6'h0A) begin n_fail++; $display("FAIL jz_target got=%h exp=0a", pc_target); end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < TO; i++) begin
            #1;
            n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL timeout_wait%0d got=%b exp=%b", i, st, S_REQ); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            run = i[0]; mem_ready = 1'b1; #1;
            n_tests++; if (st !== S_FAULT) begin n_fail++; $display("FAIL timeout_sticky%0d got=%b exp=%b", i, st, S_FAULT); end
            tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; run = 1'b0; #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL timeout_reset got=%b exp=%b", st, S_NONE); end

        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        mem_ready = 1'b1; rdata = 8'h00; #1;
        n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL ready_last_wait got=%b exp=%b", st, S_REQ); end
        tick(); #1;
        n_tests++; if (st !== S_OP) begin n_fail++; $display("FAIL ready_last_decode got=%b exp=%b", st, S_OP); end
        tick(); #1;
        n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL ready_last_next got=%b exp=%b", st, S_REQ); end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; rdata = 8'hC0;
        tick(); tick(); #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL halt_decode got=%b exp=%b", st, S_NONE); end
        n_tests++; if (ir_out !== 8'hC0) begin n_fail++; $display("FAIL halt_ir got=%h exp=c0", ir_out); end
        tick();
        for (int i = 0; i < 4; i++) begin
            run = i[0]; #1;
            n_tests++; if (st !== S_HALTED) begin n_fail++; $display("FAIL halt_sticky%0d got=%b exp=%b", i, st, S_HALTED); end
            tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; run = 1'b0; #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL halt_reset got=%b exp=%b", st, S_NONE); end
        n_tests++; if (ir_out !== 8'h00) begin n_fail++; $display("FAIL halt_reset_ir got=%h exp=00", ir_out); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; rdata = 8'h05;
        tick();
        reset = 1'b1; #1;
        n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL rstfetch_pre got=%b exp=%b", st, S_REQ); end
        tick();
        reset = 1'b0; run = 1'b0; #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL rstfetch_status got=%b exp=%b", st, S_NONE); end
        n_tests++; if (ir_out !== 8'h00) begin n_fail++; $display("FAIL rstfetch_ir got=%h exp=00", ir_out); end
    endtask

    task automatic test_run_drop();
        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        tick(); tick(); tick();
        run = 1'b0;
        tick();
        mem_ready = 1'b1; rdata = 8'h41;
        tick(); #1;
        n_tests++; if (st !== S_LD) begin n_fail++; $display("FAIL rundrop_decode got=%b exp=%b", st, S_LD); end
        tick(); #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL rundrop_idle got=%b exp=%b", st, S_NONE); end
        tick(); #1;
        n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL rundrop_stay got=%b exp=%b", st, S_NONE); end
    endtask

    // Each instruction: w wait cycles, one accept cycle, one decode cycle,
    // and an idle cycle whenever RUN was low during decode.
    task automatic test_random();
        logic [1:0] op;
        logic [7:0] word;
        logic [5:0] exp;
        logic       c;
        logic       stay;
        int         w;
        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 40; k++) begin
            w    = $urandom_range(0, TO - 1);
            op   = 2'($urandom_range(0, 2));
            word = {op, 6'($urandom)};
            c    = 1'($urandom_range(0, 1));
            stay = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < w; j++) begin
                mem_ready = 1'b0; rdata = 8'($urandom); #1;
                n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL rand%0d_wait%0d got=%b exp=%b", k, j, st, S_REQ); end
                tick();
            end
            mem_ready = 1'b1; rdata = word; #1;
            n_tests++; if (st !== S_REQ) begin n_fail++; $display("FAIL rand%0d_accept got=%b exp=%b", k, st, S_REQ); end
            tick();
            cond = c; run = stay; mem_ready = 1'($urandom_range(0, 1)); #1;
            exp = {1'b0, 1'b1, (op == 2'b01) || (op == 2'b10 && c), (op == 2'b00), 2'b00};
            n_tests++; if (st !== exp) begin n_fail++; $display("FAIL rand%0d_decode word=%h got=%b exp=%b", k, word, st, exp); end
            n_tests++; if (ir_out !== word) begin n_fail++; $display("FAIL rand%0d_ir got=%h exp=%h", k, ir_out, word); end
            n_tests++; if (pc_target !== word[5:0]) begin n_fail++; $display("FAIL rand%0d_target got=%h exp=%h", k, pc_target, word[5:0]); end
            tick();
            if (!stay) begin
                run = 1'b1; mem_ready = 1'b0; #1;
                n_tests++; if (st !== S_NONE) begin n_fail++; $display("FAIL rand%0d_idle got=%b exp=%b", k, st, S_NONE); end
                tick();
            end
            run = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_jz();
        test_timeout();
        test_halt();
        test_reset_mid_fetch();
        test_run_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
